// File: rtl/multi_cycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// MultiCycleCtrlIf
// Bundle between the multi-cycle controller and its datapath.
//
// Signals
//   Instr      [31:0]  instruction held in the datapath IR
//   PC_Write           PC <= PC+4 on this edge
//   IR_Write           IR <= IM[PC] on this edge
//   RegDst             1 = write register Instr[15:11], 0 = Instr[20:16]
//   AluSrc             1 = ALU operand 2 is Extend32, 0 = BusB
//   MemToReg           1 = register write data is LoadData, 0 = AluOut
//   beq, bgtz          branch qualifiers, gated by zero/greater in datapath
//   jal, jr            jump selects (jal also forces reg 31 / link data)
//   GPR_Write          register-file write enable
//   DM_Write           data-memory write enable
//   LuiExt, SignExt    extender mode (both 0 = zero-extend)
//   ALUOp      [2:0]   000 add, 001 sub, 010 or
//   State      [2:0]   IF=0, ID=1, EX=2, MEM=3, WB=4
//   Retire             pulse on the last cycle of each instruction
//
// Modports
//   master : the controller (consumes Instr, drives every control)
//   slave  : the datapath   (drives Instr, consumes every control)
// ---------------------------------------------------------------------------
interface multi_cycle_ctrl_if;
    logic [31:0] Instr;
    logic        PC_Write;
    logic        IR_Write;
    logic        RegDst;
    logic        AluSrc;
    logic        MemToReg;
    logic        beq;
    logic        bgtz;
    logic        jal;
    logic        jr;
    logic        GPR_Write;
    logic        DM_Write;
    logic        LuiExt;
    logic        SignExt;
    logic [2:0]  ALUOp;
    logic [2:0]  State;
    logic        Retire;

    modport master (
        input  Instr,
        output PC_Write, IR_Write, RegDst, AluSrc, MemToReg,
        output beq, bgtz, jal, jr, GPR_Write, DM_Write,
        output LuiExt, SignExt, ALUOp, State, Retire
    );

    modport slave (
        output Instr,
        input  PC_Write, IR_Write, RegDst, AluSrc, MemToReg,
        input  beq, bgtz, jal, jr, GPR_Write, DM_Write,
        input  LuiExt, SignExt, ALUOp, State, Retire
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
// Moore-style control FSM for a five-state (IF/ID/EX/MEM/WB) multi-cycle
// MIPS-subset datapath.
//
// Supported: addu, subu, jr, ori, lui, lw, sw, beq, bgtz, jal.
// Any other encoding is treated as illegal and retires after ID with no
// architectural side effect.
//
// Ports
//   clk    : rising-edge clock for all state
//   reset  : synchronous, active-high; returns the FSM to IF
//   bus    : multi_cycle_ctrl_if.master (Instr in, all controls out)
// ---------------------------------------------------------------------------
module multi_cycle_ctrl (
    input  logic                   clk,
    input  logic                   reset,
    multi_cycle_ctrl_if.master     bus
);

    localparam logic [2:0] ST_IF  = 3'd0;
    localparam logic [2:0] ST_ID  = 3'd1;
    localparam logic [2:0] ST_EX  = 3'd2;
    localparam logic [2:0] ST_MEM = 3'd3;
    localparam logic [2:0] ST_WB  = 3'd4;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;

    logic [2:0] state_q;
    logic [2:0] state_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unusedInstrBits;

    logic isRType;
    logic isAddu;
    logic isSubu;
    logic isJr;
    logic isOri;
    logic isLui;
    logic isLw;
    logic isSw;
    logic isBeq;
    logic isBgtz;
    logic isJal;
    logic isLegal;
    logic isAluWb;

    logic [2:0] exAluOp;
    logic       exAluSrc;
    logic       exSignExt;
    logic       exLuiExt;

    logic pcWrite;
    logic irWrite;
    logic regDst;
    logic aluSrc;
    logic memToReg;
    logic beqSel;
    logic bgtzSel;
    logic jalSel;
    logic jrSel;
    logic gprWrite;
    logic dmWrite;
    logic luiExt;
    logic signExt;
    logic [2:0] aluOp;
    logic retire;

    // Instruction field extraction. Only opcode and funct steer control;
    // the register/immediate fields belong to the datapath.
    assign opcode          = bus.Instr[31:26];
    assign funct           = bus.Instr[5:0];
    assign unusedInstrBits = ^bus.Instr[25:6];

    // Decode of the supported subset. R-type entries need the funct match
    // too, so an R-type with an unknown funct falls through to illegal.
    assign isRType = (opcode == 6'b000000);
    assign isAddu  = isRType && (funct == 6'b100001);
    assign isSubu  = isRType && (funct == 6'b100011);
    assign isJr    = isRType && (funct == 6'b001000);
    assign isOri   = (opcode == 6'b001101);
    assign isLui   = (opcode == 6'b001111);
    assign isLw    = (opcode == 6'b100011);
    assign isSw    = (opcode == 6'b101011);
    assign isBeq   = (opcode == 6'b000100);
    assign isBgtz  = (opcode == 6'b000111);
    assign isJal   = (opcode == 6'b000011);

    assign isLegal = isAddu | isSubu | isJr | isOri | isLui |
                     isLw | isSw | isBeq | isBgtz | isJal;

    // Instructions whose result comes straight from the ALU into the
    // register file and therefore go EX -> WB.
    assign isAluWb = isAddu | isSubu | isOri | isLui;

    // ALU/extender setup chosen in EX. MEM and WB re-drive the same values
    // so the ALU output (address or result) stays valid while it is used.
    always_comb begin
        exAluOp   = ALU_ADD;
        exAluSrc  = 1'b0;
        exSignExt = 1'b0;
        exLuiExt  = 1'b0;
        if (isSubu) begin
            exAluOp = ALU_SUB;
        end
        if (isOri) begin
            exAluOp  = ALU_OR;
            exAluSrc = 1'b1;
        end
        if (isLui) begin
            exAluOp  = ALU_OR;
            exAluSrc = 1'b1;
            exLuiExt = 1'b1;
        end
        if (isLw || isSw) begin
            exAluOp   = ALU_ADD;
            exAluSrc  = 1'b1;
            exSignExt = 1'b1;
        end
        if (isBeq) begin
            exAluOp   = ALU_SUB;
            exSignExt = 1'b1;
        end
        if (isBgtz) begin
            exSignExt = 1'b1;
        end
    end

    // Next-state and raw Moore outputs from the registered state and the
    // held instruction. Every output defaults to 0 so anything not named
    // for a state stays low; states 5..7 fall into the default arm, which
    // drives nothing and heads back to IF.
    always_comb begin
        state_d  = ST_IF;
        pcWrite  = 1'b0;
        irWrite  = 1'b0;
        regDst   = 1'b0;
        aluSrc   = 1'b0;
        memToReg = 1'b0;
        beqSel   = 1'b0;
        bgtzSel  = 1'b0;
        jalSel   = 1'b0;
        jrSel    = 1'b0;
        gprWrite = 1'b0;
        dmWrite  = 1'b0;
        luiExt   = 1'b0;
        signExt  = 1'b0;
        aluOp    = ALU_ADD;
        retire   = 1'b0;

        case (state_q)
            ST_IF: begin
                pcWrite = 1'b1;
                irWrite = 1'b1;
                state_d = ST_ID;
            end

            ST_ID: begin
                if (isJal) begin
                    jalSel  = 1'b1;
                    state_d = ST_WB;
                end else if (isJr) begin
                    jrSel   = 1'b1;
                    retire  = 1'b1;
                    state_d = ST_IF;
                end else if (!isLegal) begin
                    retire  = 1'b1;
                    state_d = ST_IF;
                end else begin
                    state_d = ST_EX;
                end
            end

            ST_EX: begin
                aluOp   = exAluOp;
                aluSrc  = exAluSrc;
                signExt = exSignExt;
                luiExt  = exLuiExt;
                beqSel  = isBeq;
                bgtzSel = isBgtz;
                if (isBeq || isBgtz) begin
                    retire  = 1'b1;
                    state_d = ST_IF;
                end else if (isLw || isSw) begin
                    state_d = ST_MEM;
                end else if (isAluWb) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_IF;
                end
            end

            ST_MEM: begin
                aluOp   = exAluOp;
                aluSrc  = exAluSrc;
                signExt = exSignExt;
                if (isSw) begin
                    dmWrite = 1'b1;
                    retire  = 1'b1;
                    state_d = ST_IF;
                end else if (isLw) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_IF;
                end
            end

            ST_WB: begin
                aluOp    = exAluOp;
                aluSrc   = exAluSrc;
                signExt  = exSignExt;
                luiExt   = exLuiExt;
                gprWrite = 1'b1;
                retire   = 1'b1;
                regDst   = isAddu | isSubu;
                memToReg = isLw;
                jalSel   = isJal;
                state_d  = ST_IF;
            end

            default: begin
                state_d = ST_IF;
            end
        endcase
    end

    // State register. Reset is synchronous, so a reset seen at any edge
    // lands in IF regardless of where the instruction was.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Because reset is synchronous the state is still mid-instruction during
    // the reset cycle; masking the side-effecting strobes with reset here is
    // what guarantees an aborted instruction commits nothing in that cycle.
    // Mux selects and ALU setup are harmless and pass through unmasked.
    assign bus.PC_Write  = pcWrite  & ~reset;
    assign bus.IR_Write  = irWrite  & ~reset;
    assign bus.GPR_Write = gprWrite & ~reset;
    assign bus.DM_Write  = dmWrite  & ~reset;
    assign bus.jal       = jalSel   & ~reset;
    assign bus.jr        = jrSel    & ~reset;
    assign bus.beq       = beqSel   & ~reset;
    assign bus.bgtz      = bgtzSel  & ~reset;
    assign bus.Retire    = retire   & ~reset;

    assign bus.RegDst    = regDst;
    assign bus.AluSrc    = aluSrc;
    assign bus.MemToReg  = memToReg;
    assign bus.LuiExt    = luiExt;
    assign bus.SignExt   = signExt;
    assign bus.ALUOp     = aluOp;
    assign bus.State     = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_ctrl
// Table-driven bench for multi_cycle_ctrl. Each table entry holds an
// instruction and its hand-derived per-cycle outputs; expected cycles are
// queued as the instruction is driven and popped as the DUT is sampled.
// ---------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam logic [13:0] F_PCW  = 14'h2000;
    localparam logic [13:0] F_IRW  = 14'h1000;
    localparam logic [13:0] F_RDST = 14'h0800;
    localparam logic [13:0] F_ASRC = 14'h0400;
    localparam logic [13:0] F_M2R  = 14'h0200;
    localparam logic [13:0] F_BEQ  = 14'h0100;
    localparam logic [13:0] F_BGTZ = 14'h0080;
    localparam logic [13:0] F_JAL  = 14'h0040;
    localparam logic [13:0] F_JR   = 14'h0020;
    localparam logic [13:0] F_GPRW = 14'h0010;
    localparam logic [13:0] F_DMW  = 14'h0008;
    localparam logic [13:0] F_LUI  = 14'h0004;
    localparam logic [13:0] F_SEXT = 14'h0002;
    localparam logic [13:0] F_RET  = 14'h0001;

    localparam logic [13:0] F_GATED = F_PCW | F_IRW | F_GPRW | F_DMW | F_JAL |
                                      F_JR | F_BEQ | F_BGTZ | F_RET;

    typedef struct packed {
        logic [2:0]  st;
        logic [13:0] f;
        logic [2:0]  op;
    } cycExp_t;

    typedef struct {
        string         name;
        logic [31:0]   instr;
        int            n;
        cycExp_t [4:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    multi_cycle_ctrl_if bus ();

    multi_cycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    cycExp_t actualWord;
    assign actualWord = {bus.State,
                         bus.PC_Write, bus.IR_Write, bus.RegDst, bus.AluSrc,
                         bus.MemToReg, bus.beq, bus.bgtz, bus.jal, bus.jr,
                         bus.GPR_Write, bus.DM_Write, bus.LuiExt, bus.SignExt,
                         bus.Retire, bus.ALUOp};

    cycExp_t expQ[$];
    vec_t    vecs[$];
    int      vecCount  = 0;
    int      missCount = 0;

    function automatic cycExp_t cyc(input logic [2:0] st, input logic [13:0] f,
                                    input logic [2:0] op);
        cycExp_t c;
        c.st = st;
        c.f  = f;
        c.op = op;
        return c;
    endfunction

    task automatic addVec(input string name, input logic [31:0] instr, input int n,
                          input cycExp_t e0, input cycExp_t e1, input cycExp_t e2,
                          input cycExp_t e3, input cycExp_t e4);
        vec_t v;
        v.name   = name;
        v.instr  = instr;
        v.n      = n;
        v.exp[0] = e0;
        v.exp[1] = e1;
        v.exp[2] = e2;
        v.exp[3] = e3;
        v.exp[4] = e4;
        vecs.push_back(v);
    endtask

    // Pops the next queued expectation and compares it with what the DUT
    // is presenting right now.
    task automatic checkOutput(input string name);
        cycExp_t e;
        vecCount++;
        if (expQ.size() == 0) begin
            missCount++;
            $display("[TB] FAIL %s: DUT output with empty expectation queue, got st=%0d f=%04h op=%0d",
                     name, actualWord.st, actualWord.f, actualWord.op);
        end else begin
            e = expQ.pop_front();
            if (actualWord !== e) begin
                missCount++;
                $display("[TB] FAIL %s: got st=%0d f=%04h op=%0d, want st=%0d f=%04h op=%0d",
                         name, actualWord.st, actualWord.f, actualWord.op, e.st, e.f, e.op);
            end
        end
    endtask

    // Drives one instruction from the IF cycle onward. With abortAt >= 0,
    // reset is raised during that cycle of the instruction, the strobes are
    // expected masked, and the instruction ends there.
    task automatic applyStimulus(input vec_t v, input int abortAt);
        cycExp_t e;
        bus.Instr = v.instr;
        for (int k = 0; k < v.n; k++) begin
            e = v.exp[k];
            if (k == abortAt) begin
                reset = 1'b1;
                e.f   = e.f & ~F_GATED;
            end
            expQ.push_back(e);
            @(negedge clk);
            checkOutput($sformatf("%s/c%0d%s", v.name, k, (k == abortAt) ? "/rst" : ""));
            @(posedge clk);
            #1;
            if (k == abortAt) begin
                reset = 1'b0;
                break;
            end
        end
        if (bus.State !== S_IF) begin
            $display("[TB] resync after %s (state %0d)", v.name, bus.State);
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
        end
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        cycExp_t cIf;
        cycExp_t z;
        cIf = cyc(S_IF, F_PCW | F_IRW, 3'b000);
        z   = cyc(S_IF, 14'h0, 3'b000);

        addVec("addu", 32'h00221821, 4, cIf, cyc(S_ID, 0, 3'b000),
               cyc(S_EX, 0, 3'b000), cyc(S_WB, F_GPRW | F_RDST | F_RET, 3'b000), z);
        addVec("subu", 32'h00221823, 4, cIf, cyc(S_ID, 0, 3'b000),
               cyc(S_EX, 0, 3'b001), cyc(S_WB, F_GPRW | F_RDST | F_RET, 3'b001), z);
        addVec("ori", 32'h34220005, 4, cIf, cyc(S_ID, 0, 3'b000),
               cyc(S_EX, F_ASRC, 3'b010), cyc(S_WB, F_ASRC | F_GPRW | F_RET, 3'b010), z);
        addVec("lui", 32'h3C021234, 4, cIf, cyc(S_ID, 0, 3'b000),
               cyc(S_EX, F_ASRC | F_LUI, 3'b010),
               cyc(S_WB, F_ASRC | F_LUI | F_GPRW | F_RET, 3'b010), z);
        addVec("lw", 32'h8CA40008, 5, cIf, cyc(S_ID, 0, 3'b000),
               cyc(S_EX, F_ASRC | F_SEXT, 3'b000), cyc(S_MEM, F_ASRC | F_SEXT, 3'b000),
               cyc(S_WB, F_ASRC | F_SEXT | F_M2R | F_GPRW | F_RET, 3'b000));
        addVec("sw", 32'hACA40008, 4, cIf, cyc(S_ID, 0, 3'b000),
               cyc(S_EX, F_ASRC | F_SEXT, 3'b000),
               cyc(S_MEM, F_ASRC | F_SEXT | F_DMW | F_RET, 3'b000), z);
        addVec("beq", 32'h10220003, 3, cIf, cyc(S_ID, 0, 3'b000),
               cyc(S_EX, F_BEQ | F_SEXT | F_RET, 3'b001), z, z);
        addVec("bgtz", 32'h1C200004, 3, cIf, cyc(S_ID, 0, 3'b000),
               cyc(S_EX, F_BGTZ | F_SEXT | F_RET, 3'b000), z, z);
        addVec("jal", 32'h0C000010, 3, cIf, cyc(S_ID, F_JAL, 3'b000),
               cyc(S_WB, F_JAL | F_GPRW | F_RET, 3'b000), z, z);
        addVec("jr", 32'h03E00008, 2, cIf, cyc(S_ID, F_JR | F_RET, 3'b000), z, z, z);
        addVec("illegal_op", 32'hFC000000, 2, cIf, cyc(S_ID, F_RET, 3'b000), z, z, z);
        addVec("illegal_funct", 32'h00221820, 2, cIf, cyc(S_ID, F_RET, 3'b000), z, z, z);

        // Reset from an unknown power-up state: strobes must be masked in the
        // very first cycle, and after one edge the FSM sits in IF.
        reset     = 1'b1;
        bus.Instr = 32'h0;
        @(negedge clk);
        vecCount++;
        if ((actualWord.f & F_GATED) !== 14'h0) begin
            missCount++;
            $display("[TB] FAIL reset_gate: got strobes=%04h, want 0000",
                     actualWord.f & F_GATED);
        end
        @(posedge clk);
        #1;
        expQ.push_back(z);
        @(negedge clk);
        checkOutput("reset_hold");
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] directed table");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i], -1);
        end

        // Reset landing mid-instruction; each abort is followed by a full
        // instruction whose IF cycle confirms the clean restart.
        $display("[TB] reset aborts");
        applyStimulus(vecs[5], 3);
        applyStimulus(vecs[4], -1);
        applyStimulus(vecs[0], 3);
        applyStimulus(vecs[1], -1);
        applyStimulus(vecs[8], 1);
        applyStimulus(vecs[6], -1);
        applyStimulus(vecs[6], 2);
        applyStimulus(vecs[9], -1);
        applyStimulus(vecs[4], 3);
        applyStimulus(vecs[7], -1);

        $display("[TB] random mix");
        for (int r = 0; r < 24; r++) begin
            applyStimulus(vecs[$urandom_range(vecs.size() - 1, 0)], -1);
        end

        if (expQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL leftover_queue: got %0d pending, want 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
